// File: rtl/mac_pkg.sv
// Shared constants, types and helpers for the signed 8x8 multiply-accumulate lane.
package mac_pkg;
    localparam int DATA_W     = 8;
    localparam int ACC_W      = 19;
    localparam int IDX_W      = 4;
    localparam int DIM        = 8;
    localparam int RES_DEPTH  = 64;
    localparam int PROD_W     = 2 * DATA_W;
    localparam int RES_ADDR_W = $clog2(RES_DEPTH);

    typedef logic signed [DATA_W-1:0] operand_t;
    typedef logic signed [PROD_W-1:0] prod_t;
    typedef logic signed [ACC_W-1:0]  acc_t;
    typedef logic [IDX_W-1:0]         idx_t;
    typedef logic [RES_ADDR_W-1:0]    res_addr_t;

    // Row-major placement of a result element in the result memory.
    function automatic res_addr_t elem_addr(idx_t row, idx_t col);
        return res_addr_t'(DIM * int'(row) + int'(col));
    endfunction

    function automatic acc_t sext_prod(prod_t p);
        return {{(ACC_W-PROD_W){p[PROD_W-1]}}, p};
    endfunction
endpackage

// File: rtl/mac_if.sv
// Operand/tag input bus and aligned result bus of one MAC lane.
interface mac_if;
    import mac_pkg::*;

    logic      in_valid;
    operand_t  in_a;
    operand_t  in_b;
    logic      macc_clear;
    idx_t      tag_row;
    idx_t      tag_col;
    idx_t      tag_k;

    acc_t      out;
    logic      out_valid;
    idx_t      out_row;
    idx_t      out_col;
    idx_t      out_k;
    logic      res_valid;
    res_addr_t res_addr;

    modport master (
        output in_valid, in_a, in_b, macc_clear, tag_row, tag_col, tag_k,
        input  out, out_valid, out_row, out_col, out_k, res_valid, res_addr
    );

    modport slave (
        input  in_valid, in_a, in_b, macc_clear, tag_row, tag_col, tag_k,
        output out, out_valid, out_row, out_col, out_k, res_valid, res_addr
    );
endinterface

// File: rtl/mac_tag_delay.sv
// Two-cycle delay of the term valid bit and its (row, col, k) tags.
module tag_delay
    import mac_pkg::*;
#(
    parameter int W = IDX_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         src_valid,
    input  logic [W-1:0] src_row,
    input  logic [W-1:0] src_col,
    input  logic [W-1:0] src_k,
    output logic         dly_valid,
    output logic [W-1:0] dly_row,
    output logic [W-1:0] dly_col,
    output logic [W-1:0] dly_k
);
    logic         v1;
    logic [W-1:0] row1;
    logic [W-1:0] col1;
    logic [W-1:0] k1;

    // Tags only advance with a valid term so the output tags keep naming
    // the last term folded into the accumulator across input gaps.
    always_ff @(posedge clk) begin
        if (reset) begin
            v1        <= 1'b0;
            row1      <= '0;
            col1      <= '0;
            k1        <= '0;
            dly_valid <= 1'b0;
            dly_row   <= '0;
            dly_col   <= '0;
            dly_k     <= '0;
        end else begin
            v1        <= src_valid;
            dly_valid <= v1;
            if (src_valid) begin
                row1 <= src_row;
                col1 <= src_col;
                k1   <= src_k;
            end
            if (v1) begin
                dly_row <= row1;
                dly_col <= col1;
                dly_k   <= k1;
            end
        end
    end
endmodule

// File: rtl/mac.sv
// Signed MAC lane: product register, wrapping accumulator, aligned tags and
// result addressing. Define MAC_RESULT_RAM_EN to build the 64-entry result memory.
module mac
    import mac_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    mac_if.slave      bus,
    input  res_addr_t rd_addr,
    output acc_t      rd_data
);
    prod_t prod;
    logic  clear_q;
    logic  valid_q;
    acc_t  acc;
    logic  res_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            prod    <= '0;
            clear_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                prod    <= prod_t'(bus.in_a) * prod_t'(bus.in_b);
                clear_q <= bus.macc_clear;
            end
        end
    end

    // Sum wraps modulo 2^ACC_W; eight full-scale products fit without loss.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc <= '0;
        end else if (valid_q) begin
            acc <= clear_q ? sext_prod(prod) : acc + sext_prod(prod);
        end
    end

    tag_delay #(.W(IDX_W)) u_tag_delay (
        .clk       (clk),
        .reset     (reset),
        .src_valid (bus.in_valid),
        .src_row   (bus.tag_row),
        .src_col   (bus.tag_col),
        .src_k     (bus.tag_k),
        .dly_valid (bus.out_valid),
        .dly_row   (bus.out_row),
        .dly_col   (bus.out_col),
        .dly_k     (bus.out_k)
    );

    assign bus.out       = acc;
    assign res_valid     = bus.out_valid && (bus.out_k == idx_t'(DIM - 1));
    assign bus.res_valid = res_valid;
    assign bus.res_addr  = elem_addr(bus.out_row, bus.out_col);

`ifdef MAC_RESULT_RAM_EN
    acc_t mem [RES_DEPTH];

    // Read-before-write: a same-edge read of the written address sees old data.
    always_ff @(posedge clk) begin
        if (res_valid) begin
            mem[bus.res_addr] <= acc;
        end
        rd_data <= mem[rd_addr];
    end
`else
    logic unused_rd_addr;
    assign unused_rd_addr = ^rd_addr;
    assign rd_data        = '0;
`endif
endmodule

// File: tb/tb_mac.sv
// Self-checking bench for the mac lane: vector table, directed corners, random stream.
module tb_mac;
    import mac_pkg::*;

    logic      clk = 1'b0;
    logic      reset;
    res_addr_t rd_addr;
    acc_t      rd_data;

    mac_if bus ();

    mac dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus.slave),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic   valid;
        longint acc;
        int     row;
        int     col;
        int     k;
    } snap_t;

    typedef struct packed {
        int     a_base;
        int     a_step;
        int     b_val;
        int     row;
        int     col;
        longint exp_sum;
    } vec_t;

    int     n_chk  = 0;
    int     n_fail = 0;
    int     pulses = 0;

    snap_t  vis;
    snap_t  prev;
    longint m_acc;
    int     m_row, m_col, m_k;
    longint mem_m [RES_DEPTH];
    bit     mem_known [RES_DEPTH];
    longint exp_rd;
    bit     exp_rd_known;
    vec_t   vecs [5];

    function automatic longint wrap_acc(input longint v);
        longint m;
        longint r;
        m = longint'(1) << ACC_W;
        r = v % m;
        if (r < 0) r += m;
        if (r >= m / 2) r -= m;
        return r;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs();
        chk("out_valid", longint'(bus.out_valid), longint'(vis.valid));
        chk("out", longint'(bus.out), vis.acc);
        chk("out_row", longint'(bus.out_row), longint'(vis.row));
        chk("out_col", longint'(bus.out_col), longint'(vis.col));
        chk("out_k", longint'(bus.out_k), longint'(vis.k));
        chk("res_valid", longint'(bus.res_valid), longint'(vis.valid && vis.k == DIM - 1));
        chk("res_addr", longint'(bus.res_addr), longint'((DIM * vis.row + vis.col) % RES_DEPTH));
        if (exp_rd_known) chk("rd_data", longint'(rd_data), exp_rd);
        if (bus.res_valid) pulses++;
    endtask

    // Drive one cycle at the falling edge, update the model at the rising edge,
    // check at the next falling edge.
    task automatic cycle(input logic v, input int a, input int b, input logic clr,
                         input int r, input int c, input int k, input int ra, input logic rst);
        int wa;
        reset          = rst;
        bus.in_valid   = v;
        bus.in_a       = operand_t'(a);
        bus.in_b       = operand_t'(b);
        bus.macc_clear = clr;
        bus.tag_row    = idx_t'(r);
        bus.tag_col    = idx_t'(c);
        bus.tag_k      = idx_t'(k);
        rd_addr        = res_addr_t'(ra);
        @(posedge clk);
`ifdef MAC_RESULT_RAM_EN
        exp_rd_known = mem_known[ra];
        exp_rd       = mem_m[ra];
`else
        exp_rd_known = 1'b1;
        exp_rd       = 0;
`endif
        if (vis.valid && vis.k == DIM - 1) begin
            wa            = (DIM * vis.row + vis.col) % RES_DEPTH;
            mem_m[wa]     = vis.acc;
            mem_known[wa] = 1'b1;
        end
        if (rst) begin
            m_acc = 0; m_row = 0; m_col = 0; m_k = 0;
            vis   = '0;
            prev  = '0;
        end else begin
            vis = prev;
            if (v) begin
                m_acc = clr ? longint'(a * b) : wrap_acc(m_acc + longint'(a * b));
                m_row = r; m_col = c; m_k = k;
            end
            prev.valid = v;
            prev.acc   = m_acc;
            prev.row   = m_row;
            prev.col   = m_col;
            prev.k     = m_k;
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input int ra);
        cycle(1'b0, 0, 0, 1'b0, 0, 0, 0, ra, 1'b0);
    endtask

    task automatic run_element(input int a_base, input int a_step, input int b, input int row,
                               input int col, input int gap_at, input int gap_len, input int nterms);
        longint part;
        part = 0;
        for (int k = 0; k < nterms; k++) begin
            if (k == gap_at) begin
                for (int g = 0; g < gap_len; g++) begin
                    idle(0);
                    chk("gap_hold", longint'(bus.out), part);
                    chk("gap_tag_k", longint'(bus.out_k), longint'(k - 1));
                end
            end
            cycle(1'b1, a_base + a_step * k, b, k == 0, row, col, k, 0, 1'b0);
            part += longint'((a_base + a_step * k) * b);
        end
    endtask

    function automatic longint ram_val(input longint v);
`ifdef MAC_RESULT_RAM_EN
        return v;
`else
        return 0;
`endif
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rk, rr, rc, ra, a, b;
        logic v, clr;

        vecs[0] = '{a_base: 1,    a_step: 1, b_val: 2,    row: 0, col: 0, exp_sum: 72};
        vecs[1] = '{a_base: -128, a_step: 0, b_val: -128, row: 1, col: 1, exp_sum: 131072};
        vecs[2] = '{a_base: -128, a_step: 0, b_val: 127,  row: 2, col: 3, exp_sum: -130048};
        vecs[3] = '{a_base: 127,  a_step: 0, b_val: 127,  row: 3, col: 4, exp_sum: 129032};
        vecs[4] = '{a_base: -4,   a_step: 1, b_val: -5,   row: 7, col: 7, exp_sum: 20};

        vis = '0; prev = '0;
        m_acc = 0; m_row = 0; m_col = 0; m_k = 0;
        for (int i = 0; i < RES_DEPTH; i++) begin
            mem_m[i]     = 0;
            mem_known[i] = 1'b0;
        end
        exp_rd_known = 1'b0;
        exp_rd       = 0;

        reset = 1'b1;
        bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.macc_clear = 1'b0;
        bus.tag_row = '0; bus.tag_col = '0; bus.tag_k = '0;
        rd_addr = '0;
        @(negedge clk);
        cycle(1'b0, 0, 0, 1'b0, 0, 0, 0, 0, 1'b1);
        cycle(1'b0, 0, 0, 1'b0, 0, 0, 0, 0, 1'b1);
        chk("reset_out", longint'(bus.out), 0);
        chk("reset_out_valid", longint'(bus.out_valid), 0);
        chk("reset_res_valid", longint'(bus.res_valid), 0);
        idle(0);

        for (int i = 0; i < 5; i++) begin
            run_element(vecs[i].a_base, vecs[i].a_step, vecs[i].b_val, vecs[i].row, vecs[i].col, -1, 0, DIM);
            idle(0);
            chk($sformatf("vec%0d_sum", i), longint'(bus.out), vecs[i].exp_sum);
            chk($sformatf("vec%0d_res_valid", i), longint'(bus.res_valid), 1);
            idle(0);
            chk($sformatf("vec%0d_res_pulse", i), longint'(bus.res_valid), 0);
            idle(DIM * vecs[i].row + vecs[i].col);
            chk($sformatf("vec%0d_read", i), longint'(rd_data), ram_val(vecs[i].exp_sum));
        end

        // Back-to-back elements, no bubble between k=7 and the next clear.
        pulses = 0;
        run_element(1, 1, 3, 0, 1, -1, 0, DIM);
        run_element(1, 0, -1, 0, 2, -1, 0, DIM);
        idle(0);
        chk("b2b_second_sum", longint'(bus.out), -8);
        idle(0);
        chk("b2b_pulses", longint'(pulses), 2);
        idle(1);
        idle(2);
        chk("b2b_read_addr1", longint'(rd_data), ram_val(108));
        idle(0);
        chk("b2b_read_addr2", longint'(rd_data), ram_val(-8));

        // Three-cycle input gap at k=3.
        run_element(1, 1, 2, 4, 5, 3, 3, DIM);
        idle(0);
        chk("gap_sum", longint'(bus.out), 72);
        chk("gap_row", longint'(bus.out_row), 4);
        chk("gap_col", longint'(bus.out_col), 5);
        chk("gap_k", longint'(bus.out_k), 7);
        chk("gap_res_valid", longint'(bus.res_valid), 1);
        idle(0);

        // Reset after k=4 discards the partial element at address 0.
        pulses = 0;
        run_element(9, 0, 9, 0, 0, -1, 0, 5);
        cycle(1'b0, 0, 0, 1'b0, 0, 0, 0, 0, 1'b1);
        chk("midrst_out", longint'(bus.out), 0);
        chk("midrst_out_valid", longint'(bus.out_valid), 0);
        idle(0);
        idle(0);
        idle(0);
        chk("midrst_read_addr0", longint'(rd_data), ram_val(72));
        chk("midrst_no_write", longint'(pulses), 0);

        // Read of address 9 on its commit edge returns the old contents.
        run_element(1, 1, 1, 1, 1, -1, 0, DIM);
        idle(9);
        chk("coll_res_valid", longint'(bus.res_valid), 1);
        idle(9);
        chk("coll_read_old", longint'(rd_data), ram_val(131072));
        idle(9);
        chk("coll_read_new", longint'(rd_data), ram_val(36));

        // Random stream against the model, including gaps and stray clears.
        rk = 0;
        rr = int'($urandom_range(7));
        rc = int'($urandom_range(7));
        for (int n = 0; n < 600; n++) begin
            v   = ($urandom_range(3) != 0);
            a   = int'($urandom_range(255)) - 128;
            b   = int'($urandom_range(255)) - 128;
            clr = (rk == 0) || ($urandom_range(15) == 0);
            ra  = int'($urandom_range(RES_DEPTH - 1));
            cycle(v, a, b, clr, rr, rc, rk, ra, 1'b0);
            if (v) begin
                rk = (rk + 1) % DIM;
                if (rk == 0) begin
                    rr = int'($urandom_range(7));
                    rc = int'($urandom_range(7));
                end
            end
        end
        idle(0);
        idle(0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
